apb_reg_file: RTL and testbench
===============================

APB_REG_FILE -- requirements
Module: apb_reg_file

Interface
REQ-001 The block SHALL have parameter AMBA_WORD, default 32, data width of every register and bus word.
REQ-002 The block SHALL have parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 4, number of read/write configuration registers (legal range 1..16).
REQ-004 The block SHALL have port clk, input, 1, the only clock; all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port PADDR, input, AMBA_ADDR_WIDTH, byte address; register index = PADDR[5:2], upper bits ignored.
REQ-007 The block SHALL have ports PSEL, PENABLE, PWRITE, input, 1 each, APB control.
REQ-008 The block SHALL have port PWDATA, input, AMBA_WORD, write data.
REQ-009 The block SHALL have port PRDATA, output, AMBA_WORD, registered read data.
REQ-010 The block SHALL have ports PREADY, PSLVERR, output, 1 each, transfer completion and error.
REQ-011 The block SHALL have port regs_o, output, NUM_REGS*AMBA_WORD, flat concatenation of the RW registers; register i occupies bits [i*AMBA_WORD +: AMBA_WORD].
REQ-012 The block SHALL have port start_o, output, 1, one-cycle operation start pulse.
REQ-013 The block SHALL have ports busy_i and done_i, input, 1 each, core busy level and core done pulse.
REQ-014 The block SHALL have port result_i, input, AMBA_WORD, core result, sampled when done_i is high.
REQ-015 The block SHALL have port irq_o, output, 1, level interrupt equal to the sticky done bit.

Function
REQ-016 Register map SHALL be: index 0..NUM_REGS-1 = RW registers (index 0 = CTRL); index NUM_REGS = STATUS (bit0 busy_i live, bit1 done sticky, bit2 error sticky, other bits read 0); index NUM_REGS+1 = RESULT (read-only).
REQ-017 The FSM SHALL have states IDLE, ACCESS, RD_WAIT; IDLE->ACCESS when PSEL=1 and PENABLE=0.
REQ-018 In ACCESS with PSEL=1 and PENABLE=1: a write SHALL complete in that cycle (PREADY=1, zero wait states); a read SHALL go to RD_WAIT, load PRDATA, and assert PREADY=1 in the RD_WAIT cycle (one wait state); then return to IDLE.
REQ-019 If PSEL drops in ACCESS or RD_WAIT, the FSM SHALL return to IDLE with no register update and PREADY=0.
REQ-020 PSLVERR SHALL be asserted only together with PREADY for: PADDR[1:0]!=0, index > NUM_REGS+1, a write to RESULT, or a write to any RW register while busy_i=1.
REQ-021 An errored transfer SHALL leave all registers unchanged, set STATUS bit2, and return PRDATA=0.
REQ-022 PRDATA SHALL be 0 whenever PREADY=0.
REQ-023 An accepted write to CTRL with PWDATA[0]=1 SHALL pulse start_o for exactly one cycle, in the cycle after PREADY; CTRL bit0 itself SHALL be stored as written.
REQ-024 A write to STATUS SHALL be write-1-to-clear for bits 1 and 2; other STATUS bits are ignored; such a write SHALL never error.
REQ-025 On done_i=1, the block SHALL capture result_i into RESULT and set STATUS bit1; if done_i coincides with a W1C of bit1, set SHALL win.
REQ-026 Back-to-back transfers SHALL be accepted without idle cycles beyond the APB SETUP phase.

Reset
REQ-027 While rst=0, asynchronously: FSM=IDLE; all RW registers, RESULT and sticky bits = 0; PRDATA=0; PREADY=0; PSLVERR=0; start_o=0; irq_o=0.
REQ-028 Reset asserted mid-transfer SHALL abort it; after release, the block SHALL accept only a new SETUP phase.

Verification
REQ-029 The bench SHALL write 0x0000_0005 to 0x8 (NUM_REGS=4), then read 0x8 -> write PREADY in the ACCESS cycle, read PREADY one cycle later, PRDATA=0x0000_0005, regs_o[95:64]=0x5.
REQ-030 The bench SHALL write 0x1 to 0x0 with busy_i=0 -> start_o high for exactly 1 cycle after PREADY; repeat with busy_i=1 -> PSLVERR=1, no start_o, CTRL unchanged, STATUS reads 0x5.
REQ-031 The bench SHALL pulse done_i with result_i=0xDEAD_BEEF -> irq_o=1, read 0x14 returns 0xDEAD_BEEF; write 0x2 to 0x10 -> irq_o=0; the same W1C coincident with done_i -> irq_o stays 1.
REQ-032 The bench SHALL read 0x18, read 0x2, and write 0x14 -> each gets PSLVERR=1, PRDATA=0, and no register changes.
REQ-033 The bench SHALL assert rst=0 during RD_WAIT after writing 0xFFFF_FFFF to all RW registers -> PREADY=0 immediately; all reads after release return 0.
REQ-034 The bench SHALL drop PSEL in ACCESS of a write to 0x4 -> no update; a back-to-back write/read pair to 0x4 SHALL complete in 2+3 cycles.

Source files
------------

// File: rtl/apb_reg_file.sv
// apb_reg_file: APB slave register file fronting a compute core.
//   Map (word index = PADDR[5:2]):
//     0..NUM_REGS-1 : RW config registers (index 0 = CTRL, bit0 = start)
//     NUM_REGS      : STATUS  {err sticky, done sticky, busy live}, W1C on bits 2:1
//     NUM_REGS+1    : RESULT  (read-only, captured on done_i)
//   Writes complete with zero wait states; reads take one wait state.
// Ports:
//   clk, rst                  clock, async active-low reset
//   PADDR/PSEL/PENABLE/PWRITE APB request, PWDATA write data
//   PRDATA/PREADY/PSLVERR     APB response
//   regs_o                    flat RW register contents, reg i at [i*AMBA_WORD +: AMBA_WORD]
//   start_o                   one-cycle start pulse after an accepted CTRL write with bit0=1
//   busy_i/done_i/result_i    core status inputs
//   irq_o                     level interrupt = sticky done
module apb_reg_file #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int NUM_REGS        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [AMBA_WORD-1:0]          PWDATA,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs_o,
  output logic                          start_o,
  input  logic                          busy_i,
  input  logic                          done_i,
  input  logic [AMBA_WORD-1:0]          result_i,
  output logic                          irq_o
);

  localparam logic [4:0] STAT_IDX = 5'(NUM_REGS);
  localparam logic [4:0] RES_IDX  = 5'(NUM_REGS + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  state_t                             r_state, w_next;
  logic [NUM_REGS-1:0][AMBA_WORD-1:0] r_regs;
  logic [AMBA_WORD-1:0]               r_result, r_prdata, w_rdata;
  logic                               r_done, r_err, r_rd_err, r_start;

  logic [4:0] w_idx;
  logic       w_is_rw, w_dec_err, w_wr_err;
  logic       w_xfer, w_wr_acc, w_rd_acc, w_wr_ok, w_stat_wr;
  logic       w_unused_addr;

  // Only PADDR[5:0] decodes; upper bits are don't-care.
  assign w_unused_addr = ^PADDR[AMBA_ADDR_WIDTH-1:6];

  assign w_idx     = {1'b0, PADDR[5:2]};
  assign w_is_rw   = (w_idx < STAT_IDX);
  assign w_dec_err = (PADDR[1:0] != 2'b00) || (w_idx > RES_IDX);
  assign w_wr_err  = w_dec_err || (w_idx == RES_IDX) || (w_is_rw && busy_i);

  assign w_xfer    = (r_state == ACCESS) && PSEL && PENABLE;
  assign w_wr_acc  = w_xfer && PWRITE;
  assign w_rd_acc  = w_xfer && !PWRITE;
  assign w_wr_ok   = w_wr_acc && !w_wr_err;
  assign w_stat_wr = w_wr_ok && (w_idx == STAT_IDX);

  // Read mux, sampled in the ACCESS cycle and held for the wait state.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_idx == 5'(i)) w_rdata = r_regs[i];
    if (w_idx == STAT_IDX) w_rdata[2:0] = {r_err, r_done, busy_i};
    if (w_idx == RES_IDX)  w_rdata = r_result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state and APB response. A write answers in ACCESS; a read answers
  // in RD_WAIT from registered data. Losing PSEL aborts without response.
  always_comb begin
    w_next  = r_state;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    case (r_state)
      IDLE:    if (PSEL && !PENABLE) w_next = ACCESS;
      ACCESS: begin
        if (!PSEL) w_next = IDLE;
        else if (PENABLE) begin
          w_next = PWRITE ? IDLE : RD_WAIT;
          if (PWRITE) begin
            PREADY  = 1'b1;
            PSLVERR = w_wr_err;
          end
        end
      end
      RD_WAIT: begin
        w_next  = IDLE;
        PREADY  = PSEL;
        PSLVERR = PSEL && r_rd_err;
      end
      default: w_next = IDLE;
    endcase
    PRDATA = PREADY ? r_prdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prdata <= '0;
      r_rd_err <= 1'b0;
    end else begin
      // Errored reads return 0; outside a read the holding register is cleared.
      r_prdata <= (w_rd_acc && !w_dec_err) ? w_rdata : '0;
      r_rd_err <= w_rd_acc && w_dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= '0;
    end else if (w_wr_ok && w_is_rw) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_idx == 5'(i)) r_regs[i] <= PWDATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start  <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_start <= w_wr_ok && (w_idx == 5'd0) && PWDATA[0];
      if (done_i) r_result <= result_i;
      // done_i beats a coincident W1C of the done bit.
      if (done_i)                      r_done <= 1'b1;
      else if (w_stat_wr && PWDATA[1]) r_done <= 1'b0;
      // STATUS writes never error, so set and clear of err cannot collide.
      if (PSLVERR)                     r_err <= 1'b1;
      else if (w_stat_wr && PWDATA[2]) r_err <= 1'b0;
    end
  end

  assign regs_o  = r_regs;
  assign start_o = r_start;
  assign irq_o   = r_done;

endmodule

// File: tb/tb_apb_reg_file.sv
// tb_apb_reg_file: transaction-level model of the register map; a negedge
// compare process checks every DUT output against it each cycle, and the
// directed scenarios add literal expectations.
module tb_apb_reg_file;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [W-1:0]  PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic [N*W-1:0] regs_o;
  logic          start_o, busy_i, done_i, irq_o;
  logic [W-1:0]  result_i;

  always #5 clk = ~clk;

  apb_reg_file #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .regs_o(regs_o), .start_o(start_o), .busy_i(busy_i),
    .done_i(done_i), .result_i(result_i), .irq_o(irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [W-1:0] m_regs [N];
  logic         m_done, m_err;
  logic [W-1:0] m_result;
  // expected response for the current cycle
  logic         exp_ready, exp_slverr, exp_start;
  logic [W-1:0] exp_rdata;
  // effects that land on the next rising edge
  bit           p_wr, p_err, p_start, p_done;
  int           p_idx;
  logic [W-1:0] p_data, p_result;
  bit           done_at_access;
  logic [W-1:0] done_val;

  int cyc = 0;
  int ready_q[$];
  int start_cnt = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] flat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_regs[i];
    return f;
  endfunction

  function automatic bit m_error(input bit wr, input logic [AW-1:0] a);
    int  idx;
    bit  dec;
    idx = int'(a[5:2]);
    dec = (a[1:0] != 2'b00) || (idx > N + 1);
    if (!wr) return dec;
    return dec || (idx == N + 1) || (idx < N && busy_i);
  endfunction

  function automatic logic [W-1:0] m_read(input int idx);
    if (idx < N)      return m_regs[idx];
    if (idx == N)     return {29'd0, m_err, m_done, busy_i};
    if (idx == N + 1) return m_result;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_done = 0; m_err = 0; m_result = '0;
    exp_ready = 0; exp_slverr = 0; exp_start = 0; exp_rdata = '0;
    p_wr = 0; p_err = 0; p_start = 0; p_done = 0; p_idx = 0;
    p_data = '0; p_result = '0; done_at_access = 0;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (PREADY === 1'b1) ready_q.push_back(cyc);
    if (start_o === 1'b1) start_cnt++;
    if (chk_en) begin
      chk("PREADY",  128'(PREADY),  128'(exp_ready));
      chk("PSLVERR", 128'(PSLVERR), 128'(exp_slverr));
      chk("PRDATA",  128'(PRDATA),  128'(exp_rdata));
      chk("start_o", 128'(start_o), 128'(exp_start));
      chk("irq_o",   128'(irq_o),   128'(m_done));
      chk("regs_o",  128'(regs_o),  128'(flat()));
    end
  end

  // Advance one clock; commit pending model effects at the edge (W1C first,
  // then error/done sets so that a coincident set wins).
  task automatic tick();
    @(posedge clk);
    if (p_wr) begin
      if (p_idx < N) m_regs[p_idx] = p_data;
      else if (p_idx == N) begin
        if (p_data[1]) m_done = 0;
        if (p_data[2]) m_err  = 0;
      end
    end
    if (p_err) m_err = 1;
    if (p_done) begin m_done = 1; m_result = p_result; end
    exp_start = p_start;
    p_wr = 0; p_err = 0; p_start = 0; p_done = 0;
    #1;
    done_i = 0;
  endtask

  task automatic pulse_done(input logic [W-1:0] v);
    done_i = 1; result_i = v; p_done = 1; p_result = v;
    tick();
  endtask

  task automatic apb(input bit wr, input logic [AW-1:0] addr, input logic [W-1:0] data,
                     input bit drop, output logic [W-1:0] rd, output logic serr);
    int idx;
    bit err;
    logic [W-1:0] rv;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
    exp_ready = 0; exp_slverr = 0; exp_rdata = '0;
    rd = '0; serr = 0;
    tick();
    if (drop) begin
      PSEL = 0;
      tick();
      return;
    end
    idx = int'(addr[5:2]);
    err = m_error(wr, addr);
    PENABLE = 1;
    if (done_at_access) begin
      done_i = 1; result_i = done_val; p_done = 1; p_result = done_val;
      done_at_access = 0;
    end
    if (wr) begin
      exp_ready = 1; exp_slverr = err;
      if (err) p_err = 1;
      else begin
        p_wr = 1; p_idx = idx; p_data = data;
        p_start = (idx == 0) && data[0];
      end
      @(negedge clk); rd = PRDATA; serr = PSLVERR;
      tick();
    end else begin
      rv = err ? '0 : m_read(idx);
      tick();
      exp_ready = 1; exp_slverr = err; exp_rdata = rv;
      if (err) p_err = 1;
      @(negedge clk); rd = PRDATA; serr = PSLVERR;
      tick();
    end
    PSEL = 0; PENABLE = 0;
    exp_ready = 0; exp_slverr = 0; exp_rdata = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]   rd;
    logic           se;
    int             t0, s0;
    logic [N*W-1:0] snap;
    logic [AW-1:0]  a;
    bit             wr, drop;

    rst = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    busy_i = 0; done_i = 0; result_i = '0;
    model_reset();
    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_PREADY", 128'(PREADY), 128'(0));
    chk("rst_PRDATA", 128'(PRDATA), 128'(0));
    chk("rst_regs",   128'(regs_o), 128'(0));
    chk("rst_irq",    128'(irq_o),  128'(0));
    tick();
    rst = 1;
    tick();

    // write then read 0x8, with response timing
    ready_q.delete();
    t0 = cyc;
    apb(1, 20'h8, 32'h5, 0, rd, se);
    apb(0, 20'h8, 32'h0, 0, rd, se);
    chk("rd_0x8", 128'(rd), 128'h5);
    chk("regs2_0x8", 128'(regs_o[95:64]), 128'h5);
    chk("rw_ready_cycles",
        128'(ready_q.size() == 2 && ready_q[0] == t0 + 1 && ready_q[1] == t0 + 4), 128'(1));

    // start pulse, then blocked while busy
    s0 = start_cnt;
    apb(1, 20'h0, 32'h1, 0, rd, se);
    repeat (3) tick();
    chk("start_once", 128'(start_cnt - s0), 128'(1));
    busy_i = 1;
    s0 = start_cnt;
    apb(1, 20'h0, 32'h1, 0, rd, se);
    chk("busy_wr_err", 128'(se), 128'(1));
    repeat (2) tick();
    chk("busy_no_start", 128'(start_cnt - s0), 128'(0));
    chk("ctrl_kept", 128'(regs_o[31:0]), 128'h1);
    apb(0, 20'h10, 32'h0, 0, rd, se);
    chk("status_0x5", 128'(rd), 128'h5);
    busy_i = 0;

    // done / result / W1C
    pulse_done(32'hDEAD_BEEF);
    @(negedge clk); chk("irq_set", 128'(irq_o), 128'(1));
    tick();
    apb(0, 20'h14, 32'h0, 0, rd, se);
    chk("result", 128'(rd), 128'hDEAD_BEEF);
    apb(1, 20'h10, 32'h2, 0, rd, se);
    @(negedge clk); chk("irq_w1c", 128'(irq_o), 128'(0));
    tick();
    pulse_done(32'h1234_5678);
    done_at_access = 1; done_val = 32'hCAFE_0001;
    apb(1, 20'h10, 32'h2, 0, rd, se);
    @(negedge clk); chk("irq_set_wins", 128'(irq_o), 128'(1));
    tick();
    apb(0, 20'h14, 32'h0, 0, rd, se);
    chk("result2", 128'(rd), 128'hCAFE_0001);

    // error transfers
    snap = regs_o;
    apb(0, 20'h18, 32'h0, 0, rd, se);
    chk("err_rd18_slv", 128'(se), 128'(1));
    chk("err_rd18_data", 128'(rd), 128'(0));
    apb(0, 20'h2, 32'h0, 0, rd, se);
    chk("err_rd2_slv", 128'(se), 128'(1));
    chk("err_rd2_data", 128'(rd), 128'(0));
    apb(1, 20'h14, 32'h5555_5555, 0, rd, se);
    chk("err_wr14_slv", 128'(se), 128'(1));
    chk("err_regs_kept", 128'(regs_o), 128'(snap));
    apb(0, 20'h14, 32'h0, 0, rd, se);
    chk("result_kept", 128'(rd), 128'hCAFE_0001);

    // aborted write, then back-to-back pair
    apb(1, 20'h4, 32'hA5A5_A5A5, 0, rd, se);
    apb(1, 20'h4, 32'h1111_1111, 1, rd, se);
    chk("drop_no_update", 128'(regs_o[63:32]), 128'hA5A5_A5A5);
    ready_q.delete();
    t0 = cyc;
    apb(1, 20'h4, 32'h2222_2222, 0, rd, se);
    apb(0, 20'h4, 32'h0, 0, rd, se);
    chk("b2b_rd", 128'(rd), 128'h2222_2222);
    chk("b2b_ready_cycles",
        128'(ready_q.size() == 2 && ready_q[0] == t0 + 1 && ready_q[1] == t0 + 4), 128'(1));

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      busy_i = ($urandom_range(0, 3) == 0);
      a = AW'($urandom);
      a[5:2] = 4'($urandom_range(0, 7));
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wr   = ($urandom_range(0, 1) == 1);
      drop = ($urandom_range(0, 9) == 0);
      done_at_access = ($urandom_range(0, 4) == 0);
      done_val = $urandom;
      apb(wr, a, $urandom, drop, rd, se);
      if ($urandom_range(0, 5) == 0) pulse_done($urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end
    done_at_access = 0;
    busy_i = 0;

    // reset during a read wait state
    for (int i = 0; i < N; i++) apb(1, AW'(i * 4), 32'hFFFF_FFFF, 0, rd, se);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 20'h0;
    tick();
    PENABLE = 1;
    tick();
    rst = 0;
    model_reset();
    #1;
    chk("rst_mid_PREADY", 128'(PREADY), 128'(0));
    chk("rst_mid_PRDATA", 128'(PRDATA), 128'(0));
    chk("rst_mid_regs",   128'(regs_o), 128'(0));
    tick();
    tick();
    rst = 1;
    tick();
    tick();
    PSEL = 0; PENABLE = 0;
    for (int i = 0; i < N + 2; i++) begin
      apb(0, AW'(i * 4), 32'h0, 0, rd, se);
      chk("post_rst_rd", 128'(rd), 128'(0));
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
